csr_ram_responder: RTL and testbench



---
 rtl/csr_ram_pkg.sv | 17 +
 rtl/csr_ram_storage.sv | 21 ++
 rtl/csr_ram_responder.sv | 106 ++++++++++
 tb/tb_csr_ram_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/csr_ram_pkg.sv
// csr_ram_pkg: shared types, default widths and saturating increment for the CSR RAM responder
package csr_ram_pkg;
  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;
  localparam int CSR_DATA_WIDTH_DEF = 32;
  localparam int CSR_ADDRESS_WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 256;
  localparam int COUNT_WIDTH_DEF = 16;
  localparam logic [31:0] OOR_READ_VALUE_DEF = 32'hDEAD_BEEF;
  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_OOR = 2'd2;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (v == m) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/csr_ram_storage.sv
// csr_ram_storage: single-port word array with synchronous write and registered read
module csr_ram_storage #(
  parameter int WIDTH = 32,
  parameter int AW = 8,
  parameter int DEPTH = 256
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/csr_ram_responder.sv
// csr_ram_responder: CSR RAM responder with init sweep and saturating debug counters.
// Define CSR_RAM_PARITY_EN to store an even-parity bit per word and expose parity_error.
module csr_ram_responder
  import csr_ram_pkg::*;
#(
  parameter int CSR_DATA_WIDTH = CSR_DATA_WIDTH_DEF,
  parameter int CSR_ADDRESS_WIDTH = CSR_ADDRESS_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [CSR_DATA_WIDTH-1:0] OOR_READ_VALUE = CSR_DATA_WIDTH'(OOR_READ_VALUE_DEF),
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         CSR_RAM_valid,
  input  logic                         CSR_RAM_write_enable,
  input  logic [CSR_ADDRESS_WIDTH-1:0] CSR_RAM_address,
  input  logic [CSR_DATA_WIDTH-1:0]    CSR_RAM_write_data,
  output logic [CSR_DATA_WIDTH-1:0]    CSR_RAM_read_data,
  output logic                         init_done,
  input  logic                         clear_counters,
  output logic [COUNT_WIDTH-1:0]       read_count,
  output logic [COUNT_WIDTH-1:0]       write_count,
  output logic [COUNT_WIDTH-1:0]       drop_count
`ifdef CSR_RAM_PARITY_EN
  ,
  output logic                         parity_error
`endif
);
`ifdef CSR_RAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int MW = CSR_DATA_WIDTH + PW;
  state_t r_state;
  logic [CSR_ADDRESS_WIDTH-1:0] r_ptr;
  logic r_init_done;
  logic [1:0] r_src;
  logic [COUNT_WIDTH-1:0] r_read_count, r_write_count, r_drop_count;
  logic w_init, w_in_range, w_acc_rd, w_acc_wr, w_drop;
  logic [MW-1:0] w_wdata, w_mem_wd, w_mem_rd;
  assign w_init = (r_state == INIT);
  assign w_in_range = int'(CSR_RAM_address) < DEPTH;
  assign w_acc_rd = CSR_RAM_valid && !CSR_RAM_write_enable && w_in_range && !w_init;
  assign w_acc_wr = CSR_RAM_valid && CSR_RAM_write_enable && w_in_range && !w_init;
  assign w_drop = CSR_RAM_valid && (w_init || !w_in_range);
`ifdef CSR_RAM_PARITY_EN
  assign w_wdata = {^CSR_RAM_write_data, CSR_RAM_write_data};
`else
  assign w_wdata = CSR_RAM_write_data;
`endif
  assign w_mem_wd = w_init ? '0 : w_wdata;
  csr_ram_storage #(.WIDTH(MW), .AW(CSR_ADDRESS_WIDTH), .DEPTH(DEPTH)) u_storage (
    .clock   (clock),
    .i_we    (w_init || w_acc_wr),
    .i_re    (w_acc_rd),
    .i_addr  (w_init ? r_ptr : CSR_RAM_address),
    .i_wdata (w_mem_wd),
    .o_rdata (w_mem_rd)
  );
  // read_data is a view selected by the source of the last accepted read, so it holds across writes and idles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INIT;
      r_ptr <= '0;
      r_init_done <= 1'b0;
      r_src <= SRC_ZERO;
      r_read_count <= '0;
      r_write_count <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_init) begin
        r_ptr <= r_ptr + 1'b1;
        if (r_ptr == CSR_ADDRESS_WIDTH'(DEPTH - 1)) begin
          r_state <= READY;
          r_init_done <= 1'b1;
        end
      end
      if (CSR_RAM_valid && !CSR_RAM_write_enable)
        r_src <= w_init ? SRC_ZERO : w_in_range ? SRC_MEM : SRC_OOR;
      r_read_count <= clear_counters ? '0 : w_acc_rd ? COUNT_WIDTH'(sat_inc(64'(r_read_count), COUNT_WIDTH)) : r_read_count;
      r_write_count <= clear_counters ? '0 : w_acc_wr ? COUNT_WIDTH'(sat_inc(64'(r_write_count), COUNT_WIDTH)) : r_write_count;
      r_drop_count <= clear_counters ? '0 : w_drop ? COUNT_WIDTH'(sat_inc(64'(r_drop_count), COUNT_WIDTH)) : r_drop_count;
    end
  end
`ifdef CSR_RAM_PARITY_EN
  logic r_chk, r_parity_error;
  // the registered word is checked the cycle after the read, once it sits in the storage output
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_chk <= 1'b0;
      r_parity_error <= 1'b0;
    end else begin
      r_chk <= w_acc_rd;
      r_parity_error <= clear_counters ? 1'b0 : (r_chk && ^w_mem_rd) ? 1'b1 : r_parity_error;
    end
  end
  assign parity_error = r_parity_error;
`endif
  assign CSR_RAM_read_data = (r_src == SRC_MEM) ? w_mem_rd[CSR_DATA_WIDTH-1:0] :
                             (r_src == SRC_OOR) ? OOR_READ_VALUE : '0;
  assign init_done = r_init_done;
  assign read_count = r_read_count;
  assign write_count = r_write_count;
  assign drop_count = r_drop_count;
endmodule

// File: tb/tb_csr_ram_responder.sv
// tb_csr_ram_responder: directed scoreboard bench for a default instance and a DEPTH=200, 4-bit-counter instance
module tb_csr_ram_responder;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic a_valid = 0, a_we = 0, a_clr = 0;
  logic [7:0] a_addr = '0;
  logic [31:0] a_wdata = '0, a_rdata;
  logic a_done;
  logic [15:0] a_rc, a_wc, a_dc;
  logic b_valid = 0, b_we = 0, b_clr = 0;
  logic [7:0] b_addr = '0;
  logic [31:0] b_wdata = '0, b_rdata;
  logic b_done;
  logic [3:0] b_rc, b_wc, b_dc;
`ifdef CSR_RAM_PARITY_EN
  logic a_perr, b_perr;
`endif
  int tests = 0, fails = 0, edges = 0;
  logic [31:0] qa[$], qb[$];
  logic [31:0] ea, eb;

  always #5 clock = ~clock;

  csr_ram_responder dut (
    .clock(clock), .reset_n(reset_n), .CSR_RAM_valid(a_valid), .CSR_RAM_write_enable(a_we),
    .CSR_RAM_address(a_addr), .CSR_RAM_write_data(a_wdata), .CSR_RAM_read_data(a_rdata),
    .init_done(a_done), .clear_counters(a_clr), .read_count(a_rc), .write_count(a_wc),
    .drop_count(a_dc)
`ifdef CSR_RAM_PARITY_EN
    , .parity_error(a_perr)
`endif
  );

  csr_ram_responder #(.DEPTH(200), .COUNT_WIDTH(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .CSR_RAM_valid(b_valid), .CSR_RAM_write_enable(b_we),
    .CSR_RAM_address(b_addr), .CSR_RAM_write_data(b_wdata), .CSR_RAM_read_data(b_rdata),
    .init_done(b_done), .clear_counters(b_clr), .read_count(b_rc), .write_count(b_wc),
    .drop_count(b_dc)
`ifdef CSR_RAM_PARITY_EN
    , .parity_error(b_perr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) edges <= reset_n ? edges + 1 : 0;

  always @(posedge clock) if (reset_n && a_valid && !a_we) begin
    #1;
    if (qa.size() == 0) chk("a_sb_empty", 32'd1, 32'd0);
    else begin
      ea = qa.pop_front();
      chk("a_read", a_rdata, ea);
    end
  end

  always @(posedge clock) if (reset_n && b_valid && !b_we) begin
    #1;
    if (qb.size() == 0) chk("b_sb_empty", 32'd1, 32'd0);
    else begin
      eb = qb.pop_front();
      chk("b_read", b_rdata, eb);
    end
  end

  task automatic a_req(input logic we, input logic [7:0] addr, input logic [31:0] d, input logic [31:0] exp);
    a_valid = 1; a_we = we; a_addr = addr; a_wdata = d;
    if (!we) qa.push_back(exp);
    @(negedge clock);
    a_valid = 0; a_we = 0;
  endtask

  task automatic b_req(input logic we, input logic [7:0] addr, input logic [31:0] d, input logic [31:0] exp);
    b_valid = 1; b_we = we; b_addr = addr; b_wdata = d;
    if (!we) qb.push_back(exp);
    @(negedge clock);
    b_valid = 0; b_we = 0;
  endtask

  task automatic wait_done();
    while (!a_done && edges < 400) @(negedge clock);
    chk("init_latency", 32'(edges), 32'd256);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_counts", {a_rc, a_wc} | 32'(a_dc), 32'd0);
    reset_n = 1;
    repeat (9) @(negedge clock);
    a_req(0, 8'h05, '0, 32'd0);
    chk("init_drop", 32'(a_dc), 32'd1);
    chk("init_rc", 32'(a_rc), 32'd0);
    wait_done();
    chk("b_done", 32'(b_done), 32'd1);
    a_req(1, 8'h10, 32'h1234_5678, '0);
    a_req(0, 8'h10, '0, 32'h1234_5678);
    chk("wc1", 32'(a_wc), 32'd1);
    chk("rc1", 32'(a_rc), 32'd1);
    a_req(1, 8'h00, 32'h0000_00FF, '0);
    a_req(1, 8'hFF, 32'hFFFF_FFFF, '0);
    a_req(0, 8'hFF, '0, 32'hFFFF_FFFF);
    a_req(0, 8'h00, '0, 32'h0000_00FF);
    a_req(0, 8'h80, '0, 32'd0);
    chk("wc3", 32'(a_wc), 32'd3);
    chk("rc4", 32'(a_rc), 32'd4);
    a_req(0, 8'h10, '0, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_idle", a_rdata, 32'h1234_5678);
    end
    a_req(1, 8'h10, 32'hCAFE_F00D, '0);
    chk("hold_write", a_rdata, 32'h1234_5678);
    a_req(0, 8'h10, '0, 32'hCAFE_F00D);
    b_req(1, 8'hC8, 32'hAAAA_AAAA, '0);
    b_req(0, 8'hC8, '0, 32'hDEAD_BEEF);
    chk("b_drop2", 32'(b_dc), 32'd2);
    chk("b_wc0", 32'(b_wc), 32'd0);
    b_req(1, 8'hC9, 32'h5555_5555, '0);
    chk("b_oor_hold", b_rdata, 32'hDEAD_BEEF);
    b_req(0, 8'hC7, '0, 32'd0);
    for (int i = 0; i < 14; i++) b_req(1, 8'(i), 32'(i), '0);
    chk("b_wc_e", 32'(b_wc), 32'hE);
    for (int i = 14; i < 17; i++) b_req(1, 8'(i), 32'(i), '0);
    chk("b_wc_sat", 32'(b_wc), 32'hF);
    b_clr = 1;
    b_req(0, 8'h03, '0, 32'd3);
    b_clr = 0;
    chk("clr_rc", 32'(b_rc), 32'd0);
    chk("clr_wc", 32'(b_wc), 32'd0);
    chk("clr_dc", 32'(b_dc), 32'd0);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    while (edges < 100) @(negedge clock);
    reset_n = 0;
    #1;
    chk("mid_done", 32'(a_done), 32'd0);
    chk("mid_rdata", a_rdata, 32'd0);
    chk("mid_counts", {a_rc, a_wc} | 32'(a_dc), 32'd0);
    @(negedge clock);
    reset_n = 1;
    wait_done();
    a_req(0, 8'h10, '0, 32'd0);
`ifdef CSR_RAM_PARITY_EN
    a_req(1, 8'h20, 32'h0000_0001, '0);
    dut.u_storage.r_mem[32][32] = ~dut.u_storage.r_mem[32][32];
    a_req(0, 8'h20, '0, 32'h0000_0001);
    repeat (2) @(negedge clock);
    chk("parity_set", 32'(a_perr), 32'd1);
    repeat (3) @(negedge clock);
    chk("parity_sticky", 32'(a_perr), 32'd1);
`endif
    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
